// File: rtl/rv_handshake_monitor.sv
// rtl/rv_handshake_monitor.sv - passive ready/valid protocol checker for NUM_CH channels
//
// Ports:
//   CLK              rising-edge clock
//   ASYNCRESETN      asynchronous active-low reset
//   clr              synchronous clear of sticky errors, counters and first-error log
//   valid/ready      per-channel handshake inputs (sampled only)
//   data             per-channel payload, channel i at [i*DATA_W +: DATA_W]
//   err_valid_drop   sticky: valid fell while a transfer was pending
//   err_data_change  sticky: payload changed while pending
//   err_timeout      sticky: stall length reached TIMEOUT
//   error            OR of all sticky error bits
//   first_err_vld    first_err_chan holds the channel of the earliest error
//   first_err_chan   earliest erroring channel, lowest index on a tie
//   xfer_count       saturating completed-transfer count per channel
module rv_handshake_monitor #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESETN,
    input  logic                     clr,
    input  logic [NUM_CH-1:0]        valid,
    input  logic [NUM_CH-1:0]        ready,
    input  logic [NUM_CH*DATA_W-1:0] data,
    output logic [NUM_CH-1:0]        err_valid_drop,
    output logic [NUM_CH-1:0]        err_data_change,
    output logic [NUM_CH-1:0]        err_timeout,
    output logic                     error,
    output logic                     first_err_vld,
    output logic [CH_W-1:0]          first_err_chan,
    output logic [NUM_CH*CNT_W-1:0]  xfer_count
);

    localparam int ST_W = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, PENDING} state_t;

    logic [NUM_CH-1:0] ev_drop;
    logic [NUM_CH-1:0] ev_change;
    logic [NUM_CH-1:0] ev_timeout;
    logic [NUM_CH-1:0] ev_any;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t            state, state_nxt;
        logic [ST_W-1:0]   stall, stall_nxt;
        logic [DATA_W-1:0] cap, cap_nxt;
        logic [CNT_W-1:0]  cnt;
        logic [DATA_W-1:0] din;
        logic              drop, chg, tmo;
        logic              e_drop, e_chg, e_tmo;

        assign din = data[gi*DATA_W +: DATA_W];

        always_comb begin
            state_nxt = state;
            stall_nxt = stall;
            cap_nxt   = cap;
            drop      = 1'b0;
            chg       = 1'b0;
            unique case (state)
                IDLE: begin
                    if (valid[gi] && !ready[gi]) begin
                        state_nxt = PENDING;
                        cap_nxt   = din;
                        stall_nxt = ST_W'(1);
                    end
                end
                PENDING: begin
                    if (!valid[gi]) begin
                        drop      = 1'b1;
                        state_nxt = IDLE;
                        stall_nxt = '0;
                    end else begin
                        // Compared even on the completing cycle.
                        if (din != cap) begin
                            chg     = 1'b1;
                            cap_nxt = din;
                        end
                        if (ready[gi]) begin
                            state_nxt = IDLE;
                            stall_nxt = '0;
                        end else if (stall != ST_W'(TIMEOUT)) begin
                            stall_nxt = stall + ST_W'(1);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
            // Fires only on the edge the counter arrives at TIMEOUT; once
            // saturated it stays there, so a long stall reports once.
            tmo = (stall_nxt == ST_W'(TIMEOUT)) && (stall != ST_W'(TIMEOUT));
        end

        // FSM, stall and capture keep running through clr so compares stay valid.
        always_ff @(posedge CLK or negedge ASYNCRESETN) begin
            if (!ASYNCRESETN) begin
                state <= IDLE;
                stall <= '0;
                cap   <= '0;
            end else begin
                state <= state_nxt;
                stall <= stall_nxt;
                cap   <= cap_nxt;
            end
        end

        always_ff @(posedge CLK or negedge ASYNCRESETN) begin
            if (!ASYNCRESETN) begin
                cnt    <= '0;
                e_drop <= 1'b0;
                e_chg  <= 1'b0;
                e_tmo  <= 1'b0;
            end else if (clr) begin
                cnt    <= '0;
                e_drop <= 1'b0;
                e_chg  <= 1'b0;
                e_tmo  <= 1'b0;
            end else begin
                if (valid[gi] && ready[gi] && (cnt != {CNT_W{1'b1}}))
                    cnt <= cnt + CNT_W'(1);
                e_drop <= e_drop | drop;
                e_chg  <= e_chg  | chg;
                e_tmo  <= e_tmo  | tmo;
            end
        end

        assign ev_drop[gi]                   = drop;
        assign ev_change[gi]                 = chg;
        assign ev_timeout[gi]                = tmo;
        assign err_valid_drop[gi]            = e_drop;
        assign err_data_change[gi]           = e_chg;
        assign err_timeout[gi]               = e_tmo;
        assign xfer_count[gi*CNT_W +: CNT_W] = cnt;
    end

    assign ev_any = ev_drop | ev_change | ev_timeout;
    assign error  = |{err_valid_drop, err_data_change, err_timeout};

    logic [CH_W-1:0] first_nxt;

    // Scan downward so the lowest active channel is the last to assign.
    always_comb begin
        first_nxt = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ev_any[i]) first_nxt = CH_W'(i);
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            first_err_vld  <= 1'b0;
            first_err_chan <= '0;
        end else if (clr) begin
            first_err_vld  <= 1'b0;
            first_err_chan <= '0;
        end else if (!first_err_vld && (|ev_any)) begin
            first_err_vld  <= 1'b1;
            first_err_chan <= first_nxt;
        end
    end

endmodule

// File: tb/tb_rv_handshake_monitor.sv
// tb/tb_rv_handshake_monitor.sv - self-checking bench for rv_handshake_monitor
module tb_rv_handshake_monitor;

    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 5;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;
    localparam int CH_W    = 2;

    logic                     CLK = 1'b0;
    logic                     ASYNCRESETN;
    logic                     clr;
    logic [NUM_CH-1:0]        valid;
    logic [NUM_CH-1:0]        ready;
    logic [NUM_CH*DATA_W-1:0] data;
    logic [NUM_CH-1:0]        err_valid_drop;
    logic [NUM_CH-1:0]        err_data_change;
    logic [NUM_CH-1:0]        err_timeout;
    logic                     error;
    logic                     first_err_vld;
    logic [CH_W-1:0]          first_err_chan;
    logic [NUM_CH*CNT_W-1:0]  xfer_count;

    rv_handshake_monitor #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .clr(clr),
        .valid(valid), .ready(ready), .data(data),
        .err_valid_drop(err_valid_drop), .err_data_change(err_data_change),
        .err_timeout(err_timeout), .error(error),
        .first_err_vld(first_err_vld), .first_err_chan(first_err_chan),
        .xfer_count(xfer_count)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: each channel is "waiting" or not, with the length of
    // the current stall run kept as an unbounded integer.
    bit          m_wait [NUM_CH];
    int          m_run  [NUM_CH];
    logic [4:0]  m_cap  [NUM_CH];
    int          m_cnt  [NUM_CH];
    bit          m_drop [NUM_CH];
    bit          m_chg  [NUM_CH];
    bit          m_tmo  [NUM_CH];
    bit          m_fv;
    int          m_fc;

    initial begin
        forever begin
            @(posedge CLK or negedge ASYNCRESETN);
            if (!ASYNCRESETN) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    m_wait[c] = 0; m_run[c] = 0; m_cap[c] = '0; m_cnt[c] = 0;
                    m_drop[c] = 0; m_chg[c] = 0; m_tmo[c] = 0;
                end
                m_fv = 0; m_fc = 0;
            end else begin
                bit ed [NUM_CH];
                bit ec [NUM_CH];
                bit et [NUM_CH];
                bit xf [NUM_CH];
                int low;
                low = -1;
                for (int c = 0; c < NUM_CH; c++) begin
                    logic [4:0] d;
                    d = data[c*DATA_W +: DATA_W];
                    ed[c] = 0; ec[c] = 0; et[c] = 0;
                    xf[c] = valid[c] && ready[c];
                    if (!m_wait[c]) begin
                        if (valid[c] && !ready[c]) begin
                            m_wait[c] = 1; m_cap[c] = d; m_run[c] = 1;
                            if (m_run[c] == TIMEOUT) et[c] = 1;
                        end
                    end else if (!valid[c]) begin
                        ed[c] = 1; m_wait[c] = 0; m_run[c] = 0;
                    end else begin
                        if (d != m_cap[c]) begin ec[c] = 1; m_cap[c] = d; end
                        if (ready[c]) begin
                            m_wait[c] = 0; m_run[c] = 0;
                        end else begin
                            m_run[c] = m_run[c] + 1;
                            if (m_run[c] == TIMEOUT) et[c] = 1;
                        end
                    end
                    if ((ed[c] || ec[c] || et[c]) && low < 0) low = c;
                end
                if (clr) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        m_cnt[c] = 0; m_drop[c] = 0; m_chg[c] = 0; m_tmo[c] = 0;
                    end
                    m_fv = 0; m_fc = 0;
                end else begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (xf[c] && m_cnt[c] < 255) m_cnt[c] = m_cnt[c] + 1;
                        m_drop[c] = m_drop[c] | ed[c];
                        m_chg[c]  = m_chg[c]  | ec[c];
                        m_tmo[c]  = m_tmo[c]  | et[c];
                    end
                    if (!m_fv && low >= 0) begin m_fv = 1; m_fc = low; end
                end
            end
        end
    end

    // Compare every output against the model midway through each cycle.
    initial begin
        forever begin
            logic [NUM_CH-1:0]       xd, xc, xt;
            logic [NUM_CH*CNT_W-1:0] xn;
            @(negedge CLK);
            for (int c = 0; c < NUM_CH; c++) begin
                xd[c] = m_drop[c]; xc[c] = m_chg[c]; xt[c] = m_tmo[c];
                xn[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
            end
            chk("model err_valid_drop",  64'(err_valid_drop),  64'(xd));
            chk("model err_data_change", 64'(err_data_change), 64'(xc));
            chk("model err_timeout",     64'(err_timeout),     64'(xt));
            chk("model error",           64'(error),           64'(|{xd, xc, xt}));
            chk("model first_err_vld",   64'(first_err_vld),   64'(m_fv));
            chk("model first_err_chan",  64'(first_err_chan),  64'(m_fc));
            chk("model xfer_count",      64'(xfer_count),      64'(xn));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic set_d(input int ch, input logic [4:0] v);
        data[ch*DATA_W +: DATA_W] = v;
    endtask

    initial begin
        ASYNCRESETN = 1'b0; clr = 1'b0; valid = '0; ready = '0; data = '0;
        tick(2);
        chk("reset error", 64'(error), 64'd0);
        chk("reset xfer_count", 64'(xfer_count), 64'd0);
        chk("reset first_err_vld", 64'(first_err_vld), 64'd0);
        ASYNCRESETN = 1'b1;
        tick(1);

        // 1: three transfers on ch0
        valid = 4'b0001; ready = 4'b0001; set_d(0, 5'h03);
        tick(3);
        chk("t1 xfer_count0", 64'(xfer_count[7:0]), 64'd3);
        chk("t1 error", 64'(error), 64'd0);
        valid = '0; ready = '0;
        tick(1);

        // 2: ch1 stalls two cycles then drops valid
        valid = 4'b0010; set_d(1, 5'h11);
        tick(2);
        valid = '0;
        tick(1);
        chk("t2 err_valid_drop", 64'(err_valid_drop), 64'b0010);
        chk("t2 first_err_vld", 64'(first_err_vld), 64'd1);
        chk("t2 first_err_chan", 64'(first_err_chan), 64'd1);

        // 3: ch2 payload changes while stalled, then completes
        valid = 4'b0100; set_d(2, 5'h0A);
        tick(2);
        set_d(2, 5'h15);
        tick(1);
        ready = 4'b0100;
        tick(1);
        chk("t3 err_data_change", 64'(err_data_change), 64'b0100);
        chk("t3 xfer_count2", 64'(xfer_count[23:16]), 64'd1);
        valid = '0; ready = '0;
        tick(1);

        // 4: ch3 timeout fires on the 16th stalled edge and only once
        valid = 4'b1000; set_d(3, 5'h1F);
        tick(15);
        chk("t4 no timeout at 15", 64'(err_timeout), 64'd0);
        tick(1);
        chk("t4 timeout at 16", 64'(err_timeout), 64'b1000);
        tick(4);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(19);
        chk("t4 no refire by 40", 64'(err_timeout), 64'd0);
        ready = 4'b1000;
        tick(1);
        valid = '0; ready = '0;
        tick(1);

        // 5: simultaneous drops on ch0 and ch2, then clr discarding a ch1 drop
        valid = 4'b0101;
        tick(1);
        valid = '0;
        tick(1);
        chk("t5 tie first_err_chan", 64'(first_err_chan), 64'd0);
        chk("t5 tie err_valid_drop", 64'(err_valid_drop), 64'b0101);
        valid = 4'b0010;
        tick(1);
        valid = '0; clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
        chk("t5 clr error", 64'(error), 64'd0);
        chk("t5 clr first_err_vld", 64'(first_err_vld), 64'd0);
        chk("t5 clr xfer_count", 64'(xfer_count), 64'd0);
        // capture still follows the payload on a clr edge
        valid = 4'b0100; set_d(2, 5'h03);
        tick(1);
        set_d(2, 5'h07); clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
        chk("t5 capture on clr", 64'(err_data_change), 64'd0);
        ready = 4'b0100;
        tick(1);
        valid = '0; ready = '0;
        tick(1);

        // 6: counter saturation, then reset in the middle of a stall
        valid = 4'b0010; ready = 4'b0010;
        tick(300);
        chk("t6 xfer_count1 sat", 64'(xfer_count[15:8]), 64'd255);
        valid = 4'b1000; ready = '0;
        tick(3);
        ASYNCRESETN = 1'b0;
        #1;
        chk("t6 async xfer_count", 64'(xfer_count), 64'd0);
        chk("t6 async first_err_vld", 64'(first_err_vld), 64'd0);
        tick(1);
        ASYNCRESETN = 1'b1;
        tick(3);
        chk("t6 no error after reset", 64'(error), 64'd0);
        ready = 4'b1000;
        tick(1);
        chk("t6 xfer_count3", 64'(xfer_count[31:24]), 64'd1);
        valid = '0; ready = '0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
